// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one cache request port between N_MASTERS requesters.
// Hits complete in the grant cycle; a miss locks the grant until the cache reports completion.
module cache_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic [N_MASTERS-1:0]    m_read_i,
    input  logic [N_MASTERS-1:0]    m_write_i,
    input  logic [4*N_MASTERS-1:0]  m_we_i,
    input  logic [32*N_MASTERS-1:0] m_addr_i,
    input  logic [32*N_MASTERS-1:0] m_data_i,
    output logic [31:0]             m_data_o,
    output logic [N_MASTERS-1:0]    m_valid_o,
    output logic [N_MASTERS-1:0]    m_gnt_o,
    output logic                    c_read_o,
    output logic                    c_write_o,
    output logic [3:0]              c_we_o,
    output logic [31:0]             c_addr_o,
    output logic [31:0]             c_data_o,
    input  logic [31:0]             c_data_i,
    input  logic                    c_valid_i,
    output logic [CNT_W-1:0]        req_cnt_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     rr_ptr, rr_next;
    logic [IDX_W-1:0]     lock_idx, lock_next;
    logic [IDX_W-1:0]     sel_idx, gnt_idx;
    logic [N_MASTERS-1:0] req;
    logic                 found, active, complete;

    assign req      = m_read_i | m_write_i;
    assign m_data_o = c_data_i;

    // Explicit wrap so non-power-of-two master counts stay in range.
    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_MASTERS - 1))
            return '0;
        else
            return idx + IDX_W'(1);
    endfunction

    always_comb begin : rr_select
        logic [IDX_W-1:0] cand;
        found   = 1'b0;
        sel_idx = rr_ptr;
        cand    = rr_ptr;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!found && req[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
            cand = inc_idx(cand);
        end
    end

    // A locked master dropping its request deactivates the port immediately.
    always_comb begin
        gnt_idx  = (state == BUSY) ? lock_idx : sel_idx;
        active   = rstn_i && ((state == BUSY) ? req[lock_idx] : found);
        complete = active && c_valid_i;
    end

    always_comb begin
        m_gnt_o   = '0;
        m_valid_o = '0;
        c_read_o  = 1'b0;
        c_write_o = 1'b0;
        c_we_o    = '0;
        c_addr_o  = '0;
        c_data_o  = '0;
        if (active) begin
            m_gnt_o[gnt_idx]   = 1'b1;
            m_valid_o[gnt_idx] = c_valid_i;
            c_write_o          = m_write_i[gnt_idx];
            c_read_o           = m_read_i[gnt_idx] & ~m_write_i[gnt_idx];
            c_we_o             = m_we_i[int'(gnt_idx)*4 +: 4];
            c_addr_o           = m_addr_i[int'(gnt_idx)*32 +: 32];
            c_data_o           = m_data_i[int'(gnt_idx)*32 +: 32];
        end
    end

    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        lock_next  = lock_idx;
        case (state)
            IDLE: begin
                if (active) begin
                    if (c_valid_i) begin
                        rr_next = inc_idx(sel_idx);
                    end else begin
                        lock_next  = sel_idx;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!active) begin
                    state_next = IDLE;
                end else if (c_valid_i) begin
                    rr_next    = inc_idx(lock_idx);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lock_idx    <= '0;
            req_cnt_o   <= '0;
            stall_cnt_o <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            lock_idx <= lock_next;
            if (complete && req_cnt_o != CNT_MAX)
                req_cnt_o <= req_cnt_o + CNT_W'(1);
            if (state == BUSY && stall_cnt_o != CNT_MAX)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: expected completions are queued at issue time and
// checked by a monitor whenever m_valid_o fires; a 4-bit-counter instance covers saturation.
module tb_cache_arbiter;
    localparam int N = 2;
    localparam int W = 68;

    logic            clk = 1'b0;
    logic            rstn_i = 1'b0;
    logic [N-1:0]    m_read_i, m_write_i;
    logic [4*N-1:0]  m_we_i;
    logic [32*N-1:0] m_addr_i, m_data_i;
    logic [31:0]     c_data_i;
    logic            c_valid_i;

    logic [31:0]     m_data_o, c_addr_o, c_data_o;
    logic [N-1:0]    m_valid_o, m_gnt_o;
    logic            c_read_o, c_write_o;
    logic [3:0]      c_we_o;
    logic [31:0]     req_cnt_o, stall_cnt_o;

    logic [31:0]     s_m_data_o, s_c_addr_o, s_c_data_o;
    logic [N-1:0]    s_m_valid_o, s_m_gnt_o;
    logic            s_c_read_o, s_c_write_o;
    logic [3:0]      s_c_we_o;
    logic [3:0]      s_req_cnt_o, s_stall_cnt_o;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    cache_arbiter #(.N_MASTERS(N), .CNT_W(32)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .m_read_i(m_read_i), .m_write_i(m_write_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o),
        .m_valid_o(m_valid_o), .m_gnt_o(m_gnt_o),
        .c_read_o(c_read_o), .c_write_o(c_write_o), .c_we_o(c_we_o),
        .c_addr_o(c_addr_o), .c_data_o(c_data_o), .c_data_i(c_data_i),
        .c_valid_i(c_valid_i), .req_cnt_o(req_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    cache_arbiter #(.N_MASTERS(N), .CNT_W(4)) dut_sat (
        .clk(clk), .rstn_i(rstn_i),
        .m_read_i(m_read_i), .m_write_i(m_write_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(s_m_data_o),
        .m_valid_o(s_m_valid_o), .m_gnt_o(s_m_gnt_o),
        .c_read_o(s_c_read_o), .c_write_o(s_c_write_o), .c_we_o(s_c_we_o),
        .c_addr_o(s_c_addr_o), .c_data_o(s_c_data_o), .c_data_i(c_data_i),
        .c_valid_i(c_valid_i), .req_cnt_o(s_req_cnt_o), .stall_cnt_o(s_stall_cnt_o)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_m(input int k, input logic rd, input logic wr, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] data);
        m_read_i[k]          = rd;
        m_write_i[k]         = wr;
        m_we_i[4*k +: 4]     = we;
        m_addr_i[32*k +: 32] = addr;
        m_data_i[32*k +: 32] = data;
    endtask

    task automatic drop_all();
        for (int k = 0; k < N; k++) set_m(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        c_valid_i = 1'b0;
    endtask

    task automatic expect_txn(input logic [1:0] v, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({v, rd, wr, addr, data});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every valid strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (m_valid_o != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got valid=%b addr=0x%0h, expected no completion",
                         m_valid_o, c_addr_o);
            end else begin
                logic [W-1:0] got, e;
                got = {m_valid_o, c_read_o, c_write_o, c_addr_o, m_data_o};
                e   = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL completion: got 0x%0h, expected 0x%0h", got, e);
                end
            end
        end
    end

    initial begin
        drop_all();
        c_data_i = 32'h1234_5678;

        // Reset state
        #2;
        check("rst_gnt", m_gnt_o, 0);
        check("rst_valid", m_valid_o, 0);
        check("rst_c_rd_wr", {c_read_o, c_write_o}, 0);
        check("rst_c_addr", c_addr_o, 0);
        check("rst_c_data_we", {c_data_o, c_we_o}, 0);
        check("rst_cnts", {req_cnt_o, stall_cnt_o}, 0);
        check("passthru", m_data_o, 32'h1234_5678);
        @(negedge clk);
        rstn_i = 1'b1;
        next_cycle();

        // Single read hit from master 0
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        c_valid_i = 1'b1;
        c_data_i  = 32'hCAFE_0001;
        expect_txn(2'b01, 1'b1, 1'b0, 32'h100, 32'hCAFE_0001);
        @(negedge clk);
        check("hit_gnt", m_gnt_o, 2'b01);
        check("hit_addr", c_addr_o, 32'h100);
        check("hit_read", c_read_o, 1'b1);
        next_cycle();
        drop_all();
        @(negedge clk);
        check("hit_req_cnt", req_cnt_o, 1);
        check("hit_stall_cnt", stall_cnt_o, 0);
        check("idle_gnt", m_gnt_o, 0);
        next_cycle();

        // Both masters hit every cycle; rr_ptr is 1, so master 1 goes first
        for (int i = 0; i < 4; i++) begin
            set_m(0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
            set_m(1, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
            c_valid_i = 1'b1;
            c_data_i  = 32'hD000_0000 + i;
            if (i % 2 == 0)
                expect_txn(2'b10, 1'b1, 1'b0, 32'h300, 32'hD000_0000 + i);
            else
                expect_txn(2'b01, 1'b1, 1'b0, 32'h200, 32'hD000_0000 + i);
            @(negedge clk);
            check("rr_gnt", m_gnt_o, (i % 2 == 0) ? 2'b10 : 2'b01);
            next_cycle();
        end
        drop_all();
        @(negedge clk);
        check("rr_req_cnt", req_cnt_o, 5);
        next_cycle();

        // Read+write from master 1: write wins
        set_m(1, 1'b1, 1'b1, 4'hF, 32'h340, 32'hDEAD_BEEF);
        c_valid_i = 1'b1;
        c_data_i  = 32'hD000_0010;
        expect_txn(2'b10, 1'b0, 1'b1, 32'h340, 32'hD000_0010);
        @(negedge clk);
        check("rw_gnt", m_gnt_o, 2'b10);
        check("rw_write", c_write_o, 1'b1);
        check("rw_read", c_read_o, 1'b0);
        check("rw_data", c_data_o, 32'hDEAD_BEEF);
        check("rw_we", c_we_o, 4'hF);
        next_cycle();
        drop_all();
        @(negedge clk);
        check("rw_req_cnt", req_cnt_o, 6);
        next_cycle();

        // Miss lock: master 0 locked for 16 BUSY cycles while master 1 keeps requesting
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
        set_m(1, 1'b0, 1'b1, 4'h3, 32'h500, 32'h55AA_55AA);
        c_valid_i = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            check("lock_gnt", m_gnt_o, 2'b01);
            check("lock_addr", c_addr_o, 32'h400);
            next_cycle();
        end
        c_valid_i = 1'b1;
        c_data_i  = 32'hE000_0400;
        expect_txn(2'b01, 1'b1, 1'b0, 32'h400, 32'hE000_0400);
        @(negedge clk);
        check("lock_done_gnt", m_gnt_o, 2'b01);
        check("lock_stall_pre", stall_cnt_o, 15);
        next_cycle();
        c_data_i = 32'hE000_0500;
        expect_txn(2'b10, 1'b0, 1'b1, 32'h500, 32'hE000_0500);
        @(negedge clk);
        check("after_lock_gnt", m_gnt_o, 2'b10);
        check("after_lock_stall", stall_cnt_o, 16);
        check("after_lock_we", c_we_o, 4'h3);
        check("after_lock_data", c_data_o, 32'h55AA_55AA);
        next_cycle();
        drop_all();
        @(negedge clk);
        check("lock_req_cnt", req_cnt_o, 8);
        next_cycle();

        // Abort: locked master 0 drops its request; master 1 is ignored that cycle
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
        c_valid_i = 1'b0;
        @(negedge clk);
        check("abort_gnt0", m_gnt_o, 2'b01);
        next_cycle();
        @(negedge clk);
        check("abort_busy_gnt", m_gnt_o, 2'b01);
        next_cycle();
        set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_m(1, 1'b1, 1'b0, 4'hF, 32'h610, 32'h0);
        @(negedge clk);
        check("abort_rd_wr", {c_read_o, c_write_o}, 0);
        check("abort_gnt", m_gnt_o, 0);
        check("abort_addr", c_addr_o, 0);
        next_cycle();
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h620, 32'h0);
        c_valid_i = 1'b1;
        c_data_i  = 32'hF000_0620;
        expect_txn(2'b01, 1'b1, 1'b0, 32'h620, 32'hF000_0620);
        @(negedge clk);
        check("post_abort_gnt", m_gnt_o, 2'b01);
        check("abort_req_cnt", req_cnt_o, 8);
        check("abort_stall_cnt", stall_cnt_o, 18);
        check("sat_stall_cnt", s_stall_cnt_o, 4'd15);
        check("sat_req_cnt_9", s_req_cnt_o, 4'd8);
        next_cycle();
        drop_all();
        @(negedge clk);
        check("post_abort_req_cnt", req_cnt_o, 9);
        next_cycle();

        // Asynchronous reset while BUSY
        set_m(0, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
        c_valid_i = 1'b0;
        next_cycle();
        next_cycle();
        #2;
        rstn_i = 1'b0;
        #1;
        check("arst_gnt", m_gnt_o, 0);
        check("arst_cnts", {req_cnt_o, stall_cnt_o}, 0);
        check("arst_sat_cnts", {s_req_cnt_o, s_stall_cnt_o}, 0);
        drop_all();
        @(negedge clk);
        rstn_i = 1'b1;
        next_cycle();

        // 20 hits: the 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++) begin
            set_m(0, 1'b1, 1'b0, 4'hF, 32'h800 + 4 * i, 32'h0);
            c_valid_i = 1'b1;
            c_data_i  = 32'h8000_0000 + i;
            expect_txn(2'b01, 1'b1, 1'b0, 32'h800 + 4 * i, 32'h8000_0000 + i);
            if (i == 0) begin
                @(negedge clk);
                check("post_rst_gnt", m_gnt_o, 2'b01);
            end
            next_cycle();
        end
        drop_all();
        @(negedge clk);
        check("sat_req_cnt", s_req_cnt_o, 4'd15);
        check("full_req_cnt", req_cnt_o, 20);
        check("sat_run_stall", stall_cnt_o, 0);
        check("pending_completions", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
